lm_sm_sequencer: RTL and testbench
==================================

// Module: lm_sm_sequencer
// PURPOSE
// Multi-cycle sequencer for the LM/SM (load/store-multiple) instructions. It walks the
// 8-bit register mask and moves one register per memory transfer.
// - SM: reads the register file, writes data memory.
// - LM: reads data memory, drives the register-file write port.
// It replaces the per-stage LM/SM decode chain and holds stall_req high to freeze the
// pipeline while a transfer is in progress.
// PARAMETERS
// DATA_W     16  register/memory data width
// ADDR_W     16  memory address width
// ADDR_STEP  1   address increment per transferred register
// PORTS
// clock      in   1       single clock; all state updates on rising edge
// reset      in   1       asynchronous, active-high
// start      in   1       one-cycle request; sampled only in IDLE
// is_store   in   1       1 = SM, 0 = LM; latched with start
// base_addr  in   ADDR_W  address of the first transfer; latched with start
// reg_mask   in   8       bit7 = R0 ... bit0 = R7; latched with start
// rf_raddr   out  3       register-file read index (SM)
// rf_rdata   in   DATA_W  combinational register-file read data for rf_raddr
// rf_we      out  1       register-file write strobe (LM)
// rf_waddr   out  3       register-file write index
// rf_wdata   out  DATA_W  register-file write data
// mem_addr   out  ADDR_W  memory address
// mem_wdata  out  DATA_W  memory write data
// mem_we     out  1       memory write request
// mem_re     out  1       memory read request
// mem_rdata  in   DATA_W  memory read data, valid when mem_ready=1
// mem_ready  in   1       completes the current request in the same cycle
// busy       out  1       state != IDLE
// stall_req  out  1       = busy; freezes fetch/decode
// done       out  1       one-cycle pulse when the sequence completes
// xfer_cnt   out  4       transfers completed in the current/last sequence (0..8)
// BEHAVIOUR
// - Reset (asynchronous): state=IDLE. busy, stall_req, done, mem_we, mem_re and rf_we all 0.
//   xfer_cnt=0, address and mask registers=0. Reset mid-sequence aborts immediately with
//   no further strobes.
// - FSM has three states: IDLE, ISSUE, DONE.
//   - IDLE, start=1, reg_mask!=0: latch mask, address and direction; clear xfer_cnt;
//     go to ISSUE.
//   - IDLE, start=1, reg_mask==0: clear xfer_cnt; go to DONE. No memory access occurs.
//   - ISSUE: current register = highest set bit of the pending mask (R0 first).
//     Memory address = the latched address, incremented by ADDR_STEP once per completed
//     transfer (not per mask bit).
//     - SM: mem_we=1, rf_raddr=cur, mem_wdata=rf_rdata.
//     - LM: mem_re=1, rf_waddr=cur, rf_wdata=mem_rdata, rf_we=mem_ready.
//     - Request is held with stable address and data until mem_ready=1.
//     - On mem_ready: clear the bit, address+=ADDR_STEP, xfer_cnt+=1. If the remaining
//       mask is 0, go to DONE; otherwise stay in ISSUE with the next register in the
//       following cycle.
//   - DONE: done=1 for exactly one cycle, busy=1, no memory strobes; then IDLE.
// - start while busy is ignored; the latched operands do not change.
// - Address arithmetic is modulo 2^ADDR_W (0xFFFF + 1 -> 0x0000). No error is flagged.
// - mem_we and mem_re are never both 1. rf_we is never 1 during SM.
// - Latency with mem_ready tied to 1: N set bits -> done asserted N+1 cycles after start.
// TESTING
// - SM, mask=8'hA0, base=0x0040, ready=1 -> writes R0@0x0040, R2@0x0041; done at
//   start+3; xfer_cnt=2.
// - LM, mask=8'h01, base=0x1000, ready delayed 3 cycles -> mem_re held 4 cycles at
//   0x1000; single rf_we to R7 with mem_rdata.
// - LM, mask=8'hFF, base=0xFFFE -> addresses FFFE, FFFF, 0000..0005; R0..R7 written in
//   order; xfer_cnt=8.
// - mask=8'h00 with start -> done pulses next cycle; mem_we, mem_re and rf_we stay 0.
// - start pulsed mid-sequence with different operands -> ignored; original sequence
//   completes unchanged.
// - reset asserted during ISSUE of an SM -> all strobes drop asynchronously; IDLE;
//   xfer_cnt=0; a new start then runs normally.

Source files
------------

// File: rtl/lm_sm_sequencer.sv
// LM/SM sequencer: walks an 8-bit register mask, moving one register per memory
// transfer, and holds the pipeline stalled while a sequence is active.
module lm_sm_sequencer #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned ADDR_STEP = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              is_store_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [7:0]        reg_mask_i,
    output logic [2:0]        rf_raddr_o,
    input  logic [DATA_W-1:0] rf_rdata_i,
    output logic              rf_we_o,
    output logic [2:0]        rf_waddr_o,
    output logic [DATA_W-1:0] rf_wdata_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_we_o,
    output logic              mem_re_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ready_i,
    output logic              busy_o,
    output logic              stall_req_o,
    output logic              done_o,
    output logic [3:0]        xfer_cnt_o
);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        mask_q, mask_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              store_q, store_d;
    logic [3:0]        cnt_q, cnt_d;

    // Current register: highest set mask bit, where bit7 maps to R0.
    logic [2:0] hi_bit;
    logic [2:0] cur_reg;
    logic [7:0] cur_onehot;

    // Priority-encode the pending mask.
    always_comb begin
        hi_bit = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (mask_q[i]) begin
                hi_bit = 3'(i);
            end
        end
        cur_reg    = 3'd7 - hi_bit;
        cur_onehot = 8'd1 << hi_bit;
    end

    // State and operand registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            mask_q  <= 8'd0;
            addr_q  <= '0;
            store_q <= 1'b0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            addr_q  <= addr_d;
            store_q <= store_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; operands are only latched from IDLE so a start while busy is ignored.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        addr_d  = addr_q;
        store_d = store_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    cnt_d = 4'd0;
                    if (reg_mask_i != 8'd0) begin
                        mask_d  = reg_mask_i;
                        addr_d  = base_addr_i;
                        store_d = is_store_i;
                        state_d = StIssue;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StIssue: begin
                if (mem_ready_i) begin
                    // Address advances per completed transfer, wrapping modulo 2^ADDR_W.
                    mask_d = mask_q & ~cur_onehot;
                    addr_d = addr_q + ADDR_W'(ADDR_STEP);
                    cnt_d  = cnt_q + 4'd1;
                    if (mask_d == 8'd0) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output decode; strobes are only active in ISSUE and are direction-exclusive.
    always_comb begin
        rf_raddr_o  = 3'd0;
        rf_we_o     = 1'b0;
        rf_waddr_o  = 3'd0;
        rf_wdata_o  = mem_rdata_i;
        mem_addr_o  = addr_q;
        mem_wdata_o = rf_rdata_i;
        mem_we_o    = 1'b0;
        mem_re_o    = 1'b0;
        busy_o      = (state_q != StIdle);
        stall_req_o = (state_q != StIdle);
        done_o      = (state_q == StDone);
        xfer_cnt_o  = cnt_q;
        if (state_q == StIssue) begin
            if (store_q) begin
                mem_we_o   = 1'b1;
                rf_raddr_o = cur_reg;
            end else begin
                mem_re_o   = 1'b1;
                rf_waddr_o = cur_reg;
                rf_we_o    = mem_ready_i;
            end
        end
    end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Scoreboard bench for lm_sm_sequencer: stimulus pushes expected transfers, a negedge
// monitor pops and checks them whenever a transfer completes or done pulses.
module tb_lm_sm_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        is_store;
    logic [15:0] base_addr;
    logic [7:0]  reg_mask;
    logic [2:0]  rf_raddr;
    logic [15:0] rf_rdata;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic        busy;
    logic        stall_req;
    logic        done;
    logic [3:0]  xfer_cnt;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned cyc     = 0;
    int unsigned start_cyc = 0;

    // kind: 0 = memory write (SM), 1 = memory read + rf write (LM), 2 = done pulse
    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] addr;
        logic [15:0] data;
        logic [2:0]  rg;
        logic [3:0]  cnt;
        logic [7:0]  lat;  // expected done latency from start; 0 = not checked
    } exp_t;

    exp_t sb_q[$];

    lm_sm_sequencer #(
        .DATA_W   (16),
        .ADDR_W   (16),
        .ADDR_STEP(1)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .is_store_i (is_store),
        .base_addr_i(base_addr),
        .reg_mask_i (reg_mask),
        .rf_raddr_o (rf_raddr),
        .rf_rdata_i (rf_rdata),
        .rf_we_o    (rf_we),
        .rf_waddr_o (rf_waddr),
        .rf_wdata_o (rf_wdata),
        .mem_addr_o (mem_addr),
        .mem_wdata_o(mem_wdata),
        .mem_we_o   (mem_we),
        .mem_re_o   (mem_re),
        .mem_rdata_i(mem_rdata),
        .mem_ready_i(mem_ready),
        .busy_o     (busy),
        .stall_req_o(stall_req),
        .done_o     (done),
        .xfer_cnt_o (xfer_cnt)
    );

    // Register file and memory models: data is a fixed function of the index/address.
    assign rf_rdata  = 16'hA0A0 + {13'd0, rf_raddr};
    assign mem_rdata = mem_addr ^ 16'h3C3C;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push(input logic [1:0] kind, input logic [15:0] addr, input logic [15:0] data,
                        input logic [2:0] rg, input logic [3:0] cnt, input logic [7:0] lat);
        exp_t e;
        e.kind = kind;
        e.addr = addr;
        e.data = data;
        e.rg   = rg;
        e.cnt  = cnt;
        e.lat  = lat;
        sb_q.push_back(e);
    endtask

    // Drives a one-cycle start; returns in the first cycle after it was sampled.
    task automatic do_start(input logic st, input logic [15:0] base, input logic [7:0] mask);
        @(posedge clk);
        #1;
        start     = 1'b1;
        is_store  = st;
        base_addr = base;
        reg_mask  = mask;
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Monitor: invariants every cycle, scoreboard pop on each completed transfer or done.
    always @(negedge clk) begin
        if (!rst) begin
            chk("we_re_exclusive", {31'd0, mem_we & mem_re}, 32'd0);
            chk("stall_eq_busy", {31'd0, stall_req}, {31'd0, busy});
            if (mem_we) chk("rf_we_during_sm", {31'd0, rf_we}, 32'd0);
            if (((mem_we || mem_re) && mem_ready) || done) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_event", {29'd0, mem_we, mem_re, done}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    case (e.kind)
                        2'd0: begin
                            chk("sm_kind", {29'd0, mem_we, mem_re, done}, 32'b100);
                            chk("sm_addr", {16'd0, mem_addr}, {16'd0, e.addr});
                            chk("sm_raddr", {29'd0, rf_raddr}, {29'd0, e.rg});
                            chk("sm_wdata", {16'd0, mem_wdata}, {16'd0, e.data});
                        end
                        2'd1: begin
                            chk("lm_kind", {29'd0, mem_we, mem_re, done}, 32'b010);
                            chk("lm_addr", {16'd0, mem_addr}, {16'd0, e.addr});
                            chk("lm_rf_we", {31'd0, rf_we}, 32'd1);
                            chk("lm_waddr", {29'd0, rf_waddr}, {29'd0, e.rg});
                            chk("lm_wdata", {16'd0, rf_wdata}, {16'd0, e.data});
                        end
                        default: begin
                            chk("done_kind", {29'd0, mem_we, mem_re, done}, 32'b001);
                            chk("done_busy", {31'd0, busy}, 32'd1);
                            chk("done_rf_we", {31'd0, rf_we}, 32'd0);
                            chk("done_xfer_cnt", {28'd0, xfer_cnt}, {28'd0, e.cnt});
                            if (e.lat != 8'd0) chk("done_latency", cyc - start_cyc, {24'd0, e.lat});
                        end
                    endcase
                end
            end
        end
    end

    // SM R0,R2 from 0x0040 with ready tied high; done three cycles after start.
    task automatic run_sm_a0();
        mem_ready = 1'b1;
        push(2'd0, 16'h0040, 16'hA0A0, 3'd0, 4'd0, 8'd0);
        push(2'd0, 16'h0041, 16'hA0A2, 3'd2, 4'd0, 8'd0);
        push(2'd2, 16'h0, 16'h0, 3'd0, 4'd2, 8'd3);
        do_start(1'b1, 16'h0040, 8'hA0);
        wait_done(20);
        chk("sm_a0_xfer_cnt_after", {28'd0, xfer_cnt}, 32'd2);
        chk("sm_a0_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        is_store  = 1'b0;
        base_addr = 16'h0;
        reg_mask  = 8'h0;
        mem_ready = 1'b1;

        // Reset state
        #12;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_stall", {31'd0, stall_req}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_strobes", {29'd0, mem_we, mem_re, rf_we}, 32'd0);
        chk("rst_xfer_cnt", {28'd0, xfer_cnt}, 32'd0);
        chk("rst_addr", {16'd0, mem_addr}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_sm_a0();

        // LM R7 from 0x1000, ready held low three cycles: mem_re stays up four cycles.
        mem_ready = 1'b0;
        push(2'd1, 16'h1000, 16'h2C3C, 3'd7, 4'd0, 8'd0);
        push(2'd2, 16'h0, 16'h0, 3'd0, 4'd1, 8'd5);
        do_start(1'b0, 16'h1000, 8'h01);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("lm_wait_re", {31'd0, mem_re}, 32'd1);
            chk("lm_wait_addr", {16'd0, mem_addr}, 32'h1000);
            chk("lm_wait_rf_we", {31'd0, rf_we}, 32'd0);
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b1;
        wait_done(20);

        // LM all registers from 0xFFFE: address wraps to 0x0000.
        push(2'd1, 16'hFFFE, 16'hC3C2, 3'd0, 4'd0, 8'd0);
        push(2'd1, 16'hFFFF, 16'hC3C3, 3'd1, 4'd0, 8'd0);
        push(2'd1, 16'h0000, 16'h3C3C, 3'd2, 4'd0, 8'd0);
        push(2'd1, 16'h0001, 16'h3C3D, 3'd3, 4'd0, 8'd0);
        push(2'd1, 16'h0002, 16'h3C3E, 3'd4, 4'd0, 8'd0);
        push(2'd1, 16'h0003, 16'h3C3F, 3'd5, 4'd0, 8'd0);
        push(2'd1, 16'h0004, 16'h3C38, 3'd6, 4'd0, 8'd0);
        push(2'd1, 16'h0005, 16'h3C39, 3'd7, 4'd0, 8'd0);
        push(2'd2, 16'h0, 16'h0, 3'd0, 4'd8, 8'd9);
        do_start(1'b0, 16'hFFFE, 8'hFF);
        wait_done(30);

        // Empty mask: done next cycle, no strobes (any strobe hits an empty scoreboard).
        push(2'd2, 16'h0, 16'h0, 3'd0, 4'd0, 8'd1);
        do_start(1'b1, 16'h0123, 8'h00);
        wait_done(10);

        // Start pulsed mid-sequence with other operands is ignored.
        mem_ready = 1'b0;
        push(2'd0, 16'h0200, 16'hA0A0, 3'd0, 4'd0, 8'd0);
        push(2'd0, 16'h0201, 16'hA0A7, 3'd7, 4'd0, 8'd0);
        push(2'd2, 16'h0, 16'h0, 3'd0, 4'd2, 8'd0);
        do_start(1'b1, 16'h0200, 8'h81);
        start     = 1'b1;
        is_store  = 1'b0;
        base_addr = 16'h0000;
        reg_mask  = 8'hFF;
        @(posedge clk);
        #1;
        start     = 1'b0;
        mem_ready = 1'b1;
        wait_done(20);

        // Asynchronous reset during an SM after one completed transfer.
        mem_ready = 1'b1;
        push(2'd0, 16'h3000, 16'hA0A0, 3'd0, 4'd0, 8'd0);
        do_start(1'b1, 16'h3000, 8'hFF);
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        chk("pre_rst_xfer_cnt", {28'd0, xfer_cnt}, 32'd1);
        chk("pre_rst_addr", {16'd0, mem_addr}, 32'h3001);
        chk("pre_rst_we", {31'd0, mem_we}, 32'd1);
        chk("pre_rst_raddr", {29'd0, rf_raddr}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_strobes", {29'd0, mem_we, mem_re, rf_we}, 32'd0);
        chk("async_rst_busy", {30'd0, busy, stall_req}, 32'd0);
        chk("async_rst_done", {31'd0, done}, 32'd0);
        chk("async_rst_xfer_cnt", {28'd0, xfer_cnt}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_sm_a0();

        chk("scoreboard_empty", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
